regfile_arbiter: RTL and testbench

- Shares the 2-read/2-write matrix register file among SUPERSCALAR_WIDTH hardware threads. Each thread owns REG_CNT registers.
- Per cycle it grants one thread both read ports (operand pair) and up to two threads the two write ports, both round-robin.
- It forms flat register-file addresses and enforces in-thread write-before-read ordering.
- It tags each read response with the thread id, aligned with the register file's 1-cycle read latency.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_arbiter_rr_pick2.sv | 42 ++++
 rtl/regfile_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg: shared sizing constants and flat-address helper for   |
// | the multi-thread register-file arbiter.                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package regfile_pkg;

  localparam int REG_CNT           = 4;
  localparam int SUPERSCALAR_WIDTH = 4;
  localparam int REG_WIDTH         = 288;

  localparam int ADDR_W = $clog2(REG_CNT * SUPERSCALAR_WIDTH);
  localparam int RID_W  = $clog2(REG_CNT);
  localparam int TID_W  = $clog2(SUPERSCALAR_WIDTH);

  // Each thread owns a contiguous block of reg_cnt registers.
  function automatic int unsigned flat_addr(input int unsigned tid,
                                            input int unsigned reg_idx,
                                            input int unsigned reg_cnt);
    return tid * reg_cnt + reg_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick2: wrapped priority search starting at ptr, returning the   |
// | first and second requesters found.                                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_pick2 #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [ID_W-1:0] ptr,
  input  logic [N-1:0]    req,
  output logic            first_v,
  output logic [ID_W-1:0] first_id,
  output logic            second_v,
  output logic [ID_W-1:0] second_id
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    first_v   = 1'b0;
    first_id  = '0;
    second_v  = 1'b0;
    second_id = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = ID_W'((32'(ptr) + 32'(k)) % 32'(N));
      if (req[w_idx]) begin
        if (!first_v) begin
          first_v  = 1'b1;
          first_id = w_idx;
        end else if (!second_v) begin
          second_v  = 1'b1;
          second_id = w_idx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_arbiter: round-robin sharing of a 2R/2W register file      |
// | among hardware threads, with in-thread write-before-read ordering. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module regfile_arbiter #(
  parameter int REG_CNT           = regfile_pkg::REG_CNT,
  parameter int SUPERSCALAR_WIDTH = regfile_pkg::SUPERSCALAR_WIDTH,
  parameter int REG_WIDTH         = regfile_pkg::REG_WIDTH,
  parameter int ADDR_W            = $clog2(REG_CNT * SUPERSCALAR_WIDTH),
  parameter int RID_W             = $clog2(REG_CNT),
  parameter int TID_W             = $clog2(SUPERSCALAR_WIDTH)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [SUPERSCALAR_WIDTH-1:0]           rd_req,
  input  logic [SUPERSCALAR_WIDTH*RID_W-1:0]     rd_src_a,
  input  logic [SUPERSCALAR_WIDTH*RID_W-1:0]     rd_src_b,
  output logic [SUPERSCALAR_WIDTH-1:0]           rd_gnt,
  input  logic [SUPERSCALAR_WIDTH-1:0]           wr_req,
  input  logic [SUPERSCALAR_WIDTH*RID_W-1:0]     wr_reg,
  input  logic [SUPERSCALAR_WIDTH*REG_WIDTH-1:0] wr_data,
  output logic [SUPERSCALAR_WIDTH-1:0]           wr_gnt,
  output logic [ADDR_W-1:0]                      port_a_read_addr,
  output logic [ADDR_W-1:0]                      port_b_read_addr,
  output logic [ADDR_W-1:0]                      port_c_write_addr,
  output logic [ADDR_W-1:0]                      port_d_write_addr,
  output logic                                   port_c_we,
  output logic                                   port_d_we,
  output logic [REG_WIDTH-1:0]                   port_c_in,
  output logic [REG_WIDTH-1:0]                   port_d_in,
  output logic                                   rsp_valid,
  output logic [TID_W-1:0]                       rsp_tid,
  output logic [31:0]                            rd_stall_cnt
);

  import regfile_pkg::*;

  localparam int c_T = SUPERSCALAR_WIDTH;

  logic [RID_W-1:0]     w_src_a   [c_T];
  logic [RID_W-1:0]     w_src_b   [c_T];
  logic [RID_W-1:0]     w_wr_reg  [c_T];
  logic [REG_WIDTH-1:0] w_wr_data [c_T];
  logic [c_T-1:0]       w_hazard;
  logic [c_T-1:0]       w_wr_req_eff;
  logic [c_T-1:0]       w_rd_elig;

  logic             w_wc_v, w_wd_v, w_rd_v;
  logic [TID_W-1:0] w_wc_id, w_wd_id, w_rd_id;

  logic [TID_W-1:0] r_wr_ptr;
  logic [TID_W-1:0] r_rd_ptr;
  logic             r_rsp_valid;
  logic [TID_W-1:0] r_rsp_tid;
  logic [31:0]      r_stall_cnt;

  // A pending write to either source blocks the read even if the write
  // is not granted this cycle; the read then sees the committed value.
  generate
    for (genvar t = 0; t < c_T; t++) begin : g_unpack
      assign w_src_a[t]   = rd_src_a[t*RID_W +: RID_W];
      assign w_src_b[t]   = rd_src_b[t*RID_W +: RID_W];
      assign w_wr_reg[t]  = wr_reg[t*RID_W +: RID_W];
      assign w_wr_data[t] = wr_data[t*REG_WIDTH +: REG_WIDTH];
      assign w_hazard[t]  = wr_req[t] &&
                            ((w_wr_reg[t] == w_src_a[t]) || (w_wr_reg[t] == w_src_b[t]));
    end
  endgenerate

  assign w_wr_req_eff = wr_req & {c_T{resetn}};
  assign w_rd_elig    = rd_req & ~w_hazard & {c_T{resetn}};

  rr_pick2 #(
    .N    (c_T),
    .ID_W (TID_W)
  ) u_wr_pick (
    .ptr       (r_wr_ptr),
    .req       (w_wr_req_eff),
    .first_v   (w_wc_v),
    .first_id  (w_wc_id),
    .second_v  (w_wd_v),
    .second_id (w_wd_id)
  );

  rr_pick2 #(
    .N    (c_T),
    .ID_W (TID_W)
  ) u_rd_pick (
    .ptr       (r_rd_ptr),
    .req       (w_rd_elig),
    .first_v   (w_rd_v),
    .first_id  (w_rd_id),
    .second_v  (),
    .second_id ()
  );

  function automatic logic [TID_W-1:0] f_next(input logic [TID_W-1:0] id);
    return (id == TID_W'(c_T - 1)) ? '0 : id + TID_W'(1);
  endfunction

  always_comb begin
    wr_gnt            = '0;
    rd_gnt            = '0;
    port_c_we         = 1'b0;
    port_d_we         = 1'b0;
    port_c_write_addr = '0;
    port_d_write_addr = '0;
    port_c_in         = '0;
    port_d_in         = '0;
    port_a_read_addr  = '0;
    port_b_read_addr  = '0;
    if (w_wc_v) begin
      wr_gnt[w_wc_id]   = 1'b1;
      port_c_we         = 1'b1;
      port_c_write_addr = ADDR_W'(flat_addr(32'(w_wc_id), 32'(w_wr_reg[w_wc_id]), REG_CNT));
      port_c_in         = w_wr_data[w_wc_id];
    end
    if (w_wd_v) begin
      wr_gnt[w_wd_id]   = 1'b1;
      port_d_we         = 1'b1;
      port_d_write_addr = ADDR_W'(flat_addr(32'(w_wd_id), 32'(w_wr_reg[w_wd_id]), REG_CNT));
      port_d_in         = w_wr_data[w_wd_id];
    end
    if (w_rd_v) begin
      rd_gnt[w_rd_id]  = 1'b1;
      port_a_read_addr = ADDR_W'(flat_addr(32'(w_rd_id), 32'(w_src_a[w_rd_id]), REG_CNT));
      port_b_read_addr = ADDR_W'(flat_addr(32'(w_rd_id), 32'(w_src_b[w_rd_id]), REG_CNT));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Pointer moves past the last thread granted a write port.
      if (w_wd_v) begin
        r_wr_ptr <= f_next(w_wd_id);
      end else if (w_wc_v) begin
        r_wr_ptr <= f_next(w_wc_id);
      end
      if (w_rd_v) begin
        r_rd_ptr <= f_next(w_rd_id);
      end
      r_rsp_valid <= w_rd_v;
      r_rsp_tid   <= w_rd_id;
      if ((|(rd_req & w_hazard)) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_tid      = r_rsp_tid;
  assign rd_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_arbiter: directed scenarios plus randomized traffic     |
// | against a behavioural arbitration model.                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_regfile_arbiter;

  localparam int T    = 4;
  localparam int RC   = 4;
  localparam int RW   = 288;
  localparam int AW   = 4;
  localparam int RIDW = 2;
  localparam int TIDW = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [T-1:0]      rd_req = '0;
  logic [T*RIDW-1:0] rd_src_a = '0;
  logic [T*RIDW-1:0] rd_src_b = '0;
  logic [T-1:0]      rd_gnt;
  logic [T-1:0]      wr_req = '0;
  logic [T*RIDW-1:0] wr_reg = '0;
  logic [T*RW-1:0]   wr_data = '0;
  logic [T-1:0]      wr_gnt;
  logic [AW-1:0]     port_a_read_addr, port_b_read_addr;
  logic [AW-1:0]     port_c_write_addr, port_d_write_addr;
  logic              port_c_we, port_d_we;
  logic [RW-1:0]     port_c_in, port_d_in;
  logic              rsp_valid;
  logic [TIDW-1:0]   rsp_tid;
  logic [31:0]       rd_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_arbiter dut (
    .clk               (clk),
    .resetn            (resetn),
    .rd_req            (rd_req),
    .rd_src_a          (rd_src_a),
    .rd_src_b          (rd_src_b),
    .rd_gnt            (rd_gnt),
    .wr_req            (wr_req),
    .wr_reg            (wr_reg),
    .wr_data           (wr_data),
    .wr_gnt            (wr_gnt),
    .port_a_read_addr  (port_a_read_addr),
    .port_b_read_addr  (port_b_read_addr),
    .port_c_write_addr (port_c_write_addr),
    .port_d_write_addr (port_d_write_addr),
    .port_c_we         (port_c_we),
    .port_d_we         (port_d_we),
    .port_c_in         (port_c_in),
    .port_d_in         (port_d_in),
    .rsp_valid         (rsp_valid),
    .rsp_tid           (rsp_tid),
    .rd_stall_cnt      (rd_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    resetn = 1'b0;
    rd_req = '0;
    wr_req = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    rd_req   = '1;
    wr_req   = '1;
    wr_reg   = 8'b11_10_01_00;
    rd_src_a = 8'b11_10_01_00;
    rd_src_b = 8'b00_00_00_00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rd_gnt, wr_gnt, port_c_we, port_d_we} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_grants: got %b expected 0", {rd_gnt, wr_gnt, port_c_we, port_d_we});
    end
    n_cmp++;
    if ({rsp_valid, rd_stall_cnt} !== 33'b0) begin
      n_err++;
      $display("FAIL reset_regs: got valid=%b stall=%0d expected 0/0", rsp_valid, rd_stall_cnt);
    end
  endtask

  task automatic test_write_rr();
    do_reset();
    rd_req = '0;
    wr_req = '1;
    wr_reg = {2'd1, 2'd0, 2'd3, 2'd2};
    for (int t = 0; t < T; t++) wr_data[t*RW +: RW] = {9{32'hA000_0000 + 32'(t)}};
    #1;
    n_cmp++;
    if ({wr_gnt, port_c_we, port_d_we, port_c_write_addr, port_d_write_addr} !== {4'b0011, 2'b11, 4'd2, 4'd7}) begin
      n_err++;
      $display("FAIL wr_rr_c0: got gnt=%b c=%0d d=%0d expected 0011/2/7", wr_gnt, port_c_write_addr, port_d_write_addr);
    end
    n_cmp++;
    if ({port_c_in, port_d_in} !== {{9{32'hA000_0000}}, {9{32'hA000_0001}}}) begin
      n_err++;
      $display("FAIL wr_rr_data: got c=%h d=%h", port_c_in, port_d_in);
    end
    @(posedge clk); #2;
    n_cmp++;
    if ({wr_gnt, port_c_write_addr, port_d_write_addr} !== {4'b1100, 4'd8, 4'd13}) begin
      n_err++;
      $display("FAIL wr_rr_c1: got gnt=%b c=%0d d=%0d expected 1100/8/13", wr_gnt, port_c_write_addr, port_d_write_addr);
    end
    @(posedge clk); #2;
    n_cmp++;
    if (wr_gnt !== 4'b0011) begin
      n_err++;
      $display("FAIL wr_rr_wrap: got %b expected 0011", wr_gnt);
    end
    wr_req = '0;
  endtask

  task automatic test_read();
    do_reset();
    wr_req = '0;
    rd_req = 4'b0100;
    rd_src_a[2*RIDW +: RIDW] = 2'd1;
    rd_src_b[2*RIDW +: RIDW] = 2'd3;
    #1;
    n_cmp++;
    if ({rd_gnt, port_a_read_addr, port_b_read_addr} !== {4'b0100, 4'd9, 4'd11}) begin
      n_err++;
      $display("FAIL read_addr: got gnt=%b a=%0d b=%0d expected 0100/9/11", rd_gnt, port_a_read_addr, port_b_read_addr);
    end
    @(posedge clk); #1;
    rd_req = '0;
    n_cmp++;
    if ({rsp_valid, rsp_tid} !== {1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL read_rsp: got valid=%b tid=%0d expected 1/2", rsp_valid, rsp_tid);
    end
    #1;
    n_cmp++;
    if ({rd_gnt, port_a_read_addr, port_b_read_addr} !== 12'b0) begin
      n_err++;
      $display("FAIL read_idle_addr: got gnt=%b a=%0d b=%0d expected 0", rd_gnt, port_a_read_addr, port_b_read_addr);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    wr_req = 4'b0010;
    wr_reg[1*RIDW +: RIDW]   = 2'd0;
    rd_req = 4'b0010;
    rd_src_a[1*RIDW +: RIDW] = 2'd0;
    rd_src_b[1*RIDW +: RIDW] = 2'd2;
    #1;
    n_cmp++;
    if ({wr_gnt, port_c_we, port_c_write_addr, rd_gnt} !== {4'b0010, 1'b1, 4'd4, 4'b0000}) begin
      n_err++;
      $display("FAIL hazard_c0: got wg=%b we=%b c=%0d rg=%b expected 0010/1/4/0000", wr_gnt, port_c_we, port_c_write_addr, rd_gnt);
    end
    @(posedge clk); #1;
    wr_req = '0;
    n_cmp++;
    if (rd_stall_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL hazard_stall: got %0d expected 1", rd_stall_cnt);
    end
    #1;
    n_cmp++;
    if ({rd_gnt, port_a_read_addr, port_b_read_addr} !== {4'b0010, 4'd4, 4'd6}) begin
      n_err++;
      $display("FAIL hazard_c1: got gnt=%b a=%0d b=%0d expected 0010/4/6", rd_gnt, port_a_read_addr, port_b_read_addr);
    end
    @(posedge clk); #1;
    rd_req = '0;
  endtask

  task automatic test_read_fairness();
    do_reset();
    wr_req   = '0;
    rd_src_a = '0;
    rd_src_b = '0;
    rd_req   = '1;
    for (int i = 0; i < 5; i++) begin
      logic [T-1:0] e_g;
      e_g = '0;
      e_g[i % T] = 1'b1;
      #1;
      n_cmp++;
      if (rd_gnt !== e_g) begin
        n_err++;
        $display("FAIL fair_gnt[%0d]: got %b expected %b", i, rd_gnt, e_g);
      end
      if (i > 0) begin
        n_cmp++;
        if ({rsp_valid, rsp_tid} !== {1'b1, TIDW'((i - 1) % T)}) begin
          n_err++;
          $display("FAIL fair_rsp[%0d]: got valid=%b tid=%0d expected 1/%0d", i, rsp_valid, rsp_tid, (i - 1) % T);
        end
      end
      @(posedge clk);
    end
    #1;
    rd_req = '0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    wr_req = 4'b0100;
    wr_reg[2*RIDW +: RIDW]   = 2'd1;
    rd_req = 4'b0010;
    rd_src_a[1*RIDW +: RIDW] = 2'd2;
    rd_src_b[1*RIDW +: RIDW] = 2'd3;
    #1;
    n_cmp++;
    if ({wr_gnt, rd_gnt} !== {4'b0100, 4'b0010}) begin
      n_err++;
      $display("FAIL midop_pre: got wg=%b rg=%b expected 0100/0010", wr_gnt, rd_gnt);
    end
    @(posedge clk); #1;
    wr_req = '0;
    rd_req = 4'b1000;
    #1;
    n_cmp++;
    if (rd_gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL midop_gnt: got %b expected 1000", rd_gnt);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midop_rsp: got %b expected 0", rsp_valid);
    end
    resetn   = 1'b1;
    rd_req   = '1;
    wr_req   = '1;
    wr_reg   = '0;
    rd_src_a = {4{2'd1}};
    rd_src_b = {4{2'd2}};
    #1;
    n_cmp++;
    if ({rd_gnt, wr_gnt} !== {4'b0001, 4'b0011}) begin
      n_err++;
      $display("FAIL midop_ptrs: got rg=%b wg=%b expected 0001/0011", rd_gnt, wr_gnt);
    end
    rd_req = '0;
    wr_req = '0;
  endtask

  task automatic test_random();
    int          m_wr_ptr, m_rd_ptr, m_rsp_tid;
    bit          m_rsp_v;
    int unsigned m_stall;
    do_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_rsp_tid = 0; m_rsp_v = 1'b0; m_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int            c_id, d_id, r_id, t;
      bit            haz [T];
      bit            any_haz;
      logic [T-1:0]  e_wg, e_rg;
      logic [AW-1:0] e_a, e_b, e_c, e_d;
      logic [RW-1:0] e_cin, e_din;
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, rd_stall_cnt} !== {m_rsp_v, m_stall}) begin
        n_err++;
        $display("FAIL rand_regs[%0d]: got valid=%b stall=%0d expected %b/%0d", cyc, rsp_valid, rd_stall_cnt, m_rsp_v, m_stall);
      end
      if (m_rsp_v) begin
        n_cmp++;
        if (rsp_tid !== TIDW'(m_rsp_tid)) begin
          n_err++;
          $display("FAIL rand_tid[%0d]: got %0d expected %0d", cyc, rsp_tid, m_rsp_tid);
        end
      end
      resetn   = ($urandom_range(0, 24) != 0);
      rd_req   = T'($urandom);
      wr_req   = T'($urandom);
      rd_src_a = 8'($urandom);
      rd_src_b = 8'($urandom);
      wr_reg   = 8'($urandom);
      for (int k = 0; k < T; k++) wr_data[k*RW +: RW] = {9{$urandom}};
      #1;
      c_id = -1; d_id = -1; r_id = -1; any_haz = 1'b0;
      for (int k = 0; k < T; k++) begin
        haz[k] = wr_req[k] && ((wr_reg[k*RIDW +: RIDW] == rd_src_a[k*RIDW +: RIDW]) ||
                               (wr_reg[k*RIDW +: RIDW] == rd_src_b[k*RIDW +: RIDW]));
        if (rd_req[k] && haz[k]) any_haz = 1'b1;
      end
      if (resetn) begin
        for (int k = 0; k < T; k++) begin
          t = (m_wr_ptr + k) % T;
          if (wr_req[t]) begin
            if (c_id < 0) c_id = t;
            else if (d_id < 0) d_id = t;
          end
        end
        for (int k = 0; k < T; k++) begin
          t = (m_rd_ptr + k) % T;
          if (r_id < 0 && rd_req[t] && !haz[t]) r_id = t;
        end
      end
      e_wg = '0; e_rg = '0; e_a = '0; e_b = '0; e_c = '0; e_d = '0; e_cin = '0; e_din = '0;
      if (c_id >= 0) begin
        e_wg[c_id] = 1'b1;
        e_c   = AW'(c_id * RC + int'(wr_reg[c_id*RIDW +: RIDW]));
        e_cin = wr_data[c_id*RW +: RW];
      end
      if (d_id >= 0) begin
        e_wg[d_id] = 1'b1;
        e_d   = AW'(d_id * RC + int'(wr_reg[d_id*RIDW +: RIDW]));
        e_din = wr_data[d_id*RW +: RW];
      end
      if (r_id >= 0) begin
        e_rg[r_id] = 1'b1;
        e_a = AW'(r_id * RC + int'(rd_src_a[r_id*RIDW +: RIDW]));
        e_b = AW'(r_id * RC + int'(rd_src_b[r_id*RIDW +: RIDW]));
      end
      n_cmp++;
      if ({wr_gnt, rd_gnt, port_c_we, port_d_we} !== {e_wg, e_rg, c_id >= 0, d_id >= 0}) begin
        n_err++;
        $display("FAIL rand_gnt[%0d]: got wg=%b rg=%b we=%b%b expected wg=%b rg=%b we=%b%b", cyc,
                 wr_gnt, rd_gnt, port_c_we, port_d_we, e_wg, e_rg, c_id >= 0, d_id >= 0);
      end
      n_cmp++;
      if ({port_a_read_addr, port_b_read_addr, port_c_write_addr, port_d_write_addr} !== {e_a, e_b, e_c, e_d}) begin
        n_err++;
        $display("FAIL rand_addr[%0d]: got a=%0d b=%0d c=%0d d=%0d expected %0d/%0d/%0d/%0d", cyc,
                 port_a_read_addr, port_b_read_addr, port_c_write_addr, port_d_write_addr, e_a, e_b, e_c, e_d);
      end
      n_cmp++;
      if ({port_c_in, port_d_in} !== {e_cin, e_din}) begin
        n_err++;
        $display("FAIL rand_data[%0d]: got c=%h expected c=%h", cyc, port_c_in, e_cin);
      end
      if (!resetn) begin
        m_wr_ptr = 0; m_rd_ptr = 0; m_rsp_v = 1'b0; m_rsp_tid = 0; m_stall = 0;
      end else begin
        if (d_id >= 0) m_wr_ptr = (d_id + 1) % T;
        else if (c_id >= 0) m_wr_ptr = (c_id + 1) % T;
        if (r_id >= 0) m_rd_ptr = (r_id + 1) % T;
        m_rsp_v   = (r_id >= 0);
        m_rsp_tid = (r_id >= 0) ? r_id : 0;
        if (any_haz && m_stall != 32'hFFFF_FFFF) m_stall++;
      end
    end
    resetn = 1'b1;
    rd_req = '0;
    wr_req = '0;
  endtask

  initial begin
    test_reset();
    test_write_rr();
    test_read();
    test_hazard();
    test_read_fairness();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
